sync_lock_sequencer: RTL and testbench
======================================

Name: sync_lock_sequencer

Overview:
- Sequences the preprocess datapath by qualifying left/right sync falls.
- Measures the sync interval and runs a lock state machine (IDLE/ACQUIRE/LOCKED/HOLDOVER).
- Gates the predicted sync_start_stable pulse so the groove sample selector and AFLL see pulses only while the scan is locked.
- Sits between the sync edge detectors and the split-sync predictor / sample-selector consumers.

Parameters:
CNT_W, 32, width of interval counter, ref_interval and timeout compare
LOCK_COUNT, 4, consecutive good intervals required to enter LOCKED (range 1..15)
MISS_LIMIT, 3, misses tolerated in HOLDOVER before dropping to ACQUIRE (range 1..15)
TOL, 64, allowed deviation, in clk cycles, of an interval from ref_interval
TIMEOUT, 1000000, cycles with no sync event before returning to IDLE

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
lsync_fall  input  1  single-cycle left sync falling-edge pulse
rsync_fall  input  1  single-cycle right sync falling-edge pulse
sync_start_stable  input  1  predicted split-sync pulse from predictor compare
capture_en  output  1  sync_start_stable gated by lock, registered (1-cycle delay)
locked  output  1  high in LOCKED or HOLDOVER
state  output  2  0=IDLE 1=ACQUIRE 2=LOCKED 3=HOLDOVER
ref_interval  output  CNT_W  current reference sync interval
miss_cnt  output  4  misses accumulated in HOLDOVER
sync_err  output  1  pulse: bad interval detected
side_err  output  1  pulse: same side twice, or both sides in one cycle
lock_lost  output  1  pulse: HOLDOVER -> ACQUIRE transition

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low on reset_n. All outputs and state are 0 on reset; state=IDLE.
- Event definition: ev = lsync_fall | rsync_fall. Both high in the same cycle is an event with side_err=1, and it is treated as a bad interval.
- Interval counter cnt:
  - Increments every cycle, saturating at 2^CNT_W-1.
  - On ev: interval = cnt, then cnt <= 1. Events at t0 and t1 therefore give interval = t1-t0.
- Side check:
  - last_side is registered on every single-sided ev (L=0, R=1).
  - In ACQUIRE, LOCKED or HOLDOVER, an ev on the same side as last_side sets side_err and counts the interval as bad.
- Good interval: |interval - ref_interval| <= TOL, evaluated at CNT_W+1 bits with no wrap, and no side error.
- State machine:
  - IDLE: first ev -> ACQUIRE, cnt <= 1, good_cnt <= 0, ref_interval unchanged.
  - ACQUIRE:
    - Good interval: good_cnt++.
    - Otherwise: ref_interval <= interval, good_cnt <= 0, sync_err=1, except for the first interval after IDLE, which loads ref_interval silently.
    - good_cnt reaching LOCK_COUNT -> LOCKED, miss_cnt <= 0.
  - LOCKED:
    - Good ev: ref_interval unchanged.
    - Bad ev: sync_err=1, miss_cnt <= 1 -> HOLDOVER.
    - Overdue (no ev and cnt == ref_interval+TOL+1): miss_cnt <= 1, cnt <= cnt-ref_interval -> HOLDOVER.
  - HOLDOVER:
    - Good ev -> LOCKED, miss_cnt <= 0.
    - Bad ev or overdue: miss_cnt++ (overdue also does cnt <= cnt-ref_interval).
    - When the incremented value equals MISS_LIMIT -> ACQUIRE, lock_lost=1, good_cnt <= 0.
- Timeout: in any non-IDLE state, cnt >= TIMEOUT with no ev -> IDLE, miss_cnt <= 0, locked=0. Timeout has priority over overdue.
- Priority within a cycle: ev beats overdue. A state transition and capture_en gating use the state registered before this cycle's update.
- capture_en: next-cycle value = sync_start_stable & (state==LOCKED | state==HOLDOVER).
- Pulse outputs: sync_err, side_err and lock_lost are registered single-cycle pulses, asserted the cycle after the causing ev.
- Reset mid-operation: immediate return to IDLE. No pulse outputs are generated on reset.

Decomposition:
- Shared package (preproc_pkg): state encoding constants (ST_IDLE..ST_HOLDOVER) and the side encoding.
- One natural sub-module, interval_meter: cnt, interval capture, saturation and good-interval compare.
- The FSM and output logic stay in the top.

Test Plan:
- Alternating L/R falls every 2000 cycles -> ACQUIRE after the 1st event; after 1 load plus 4 good intervals (6th event), state=LOCKED, ref_interval=2000; capture_en follows sync_start_stable 1 cycle late.
- Locked at 2000, one interval of 2100 (TOL=64) -> sync_err pulse, state=HOLDOVER, miss_cnt=1; next interval of 2000 -> LOCKED, miss_cnt=0.
- Locked, sync stops -> HOLDOVER at cnt=2065, miss_cnt reaches 3 about 2000 cycles later each -> lock_lost pulse, state=ACQUIRE, capture_en held 0; after 1,000,000 idle cycles -> IDLE.
- Two consecutive lsync_fall in ACQUIRE -> side_err pulse, good_cnt=0, ref_interval reloaded.
- lsync_fall and rsync_fall in the same cycle while LOCKED -> side_err=1, sync_err=1, HOLDOVER.
- reset_n low for 1 cycle while LOCKED -> asynchronously all outputs 0, state=IDLE, no pulses; relock after 6 events.

Source files
------------

// File: rtl/sync_lock_sequencer_pkg.sv
// Shared encodings for the sync lock sequencer: lock-state codes and
// the sync side identifier.
package sync_lock_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } state_e;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_e;

endpackage

// File: rtl/sync_lock_sequencer_if.sv
// Sync-event inputs and lock-status outputs of the sync lock sequencer.
// The master side is the edge detector / predictor environment.
interface sync_lock_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             lsync_fall;
  logic             rsync_fall;
  logic             sync_start_stable;
  logic             capture_en;
  logic             locked;
  logic [1:0]       state;
  logic [CNT_W-1:0] ref_interval;
  logic [3:0]       miss_cnt;
  logic             sync_err;
  logic             side_err;
  logic             lock_lost;

  modport master (
    output lsync_fall, rsync_fall, sync_start_stable,
    input  capture_en, locked, state, ref_interval, miss_cnt,
           sync_err, side_err, lock_lost
  );

  modport slave (
    input  lsync_fall, rsync_fall, sync_start_stable,
    output capture_en, locked, state, ref_interval, miss_cnt,
           sync_err, side_err, lock_lost
  );
endinterface

// File: rtl/sync_lock_sequencer_interval_meter.sv
// Saturating cycle counter between sync events, with the tolerance,
// overdue and timeout compares against the reference interval.
module sync_lock_sequencer_interval_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TOL     = 64,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ev_i,
  input  logic             rebase_i,
  input  logic [CNT_W-1:0] ref_i,
  output logic [CNT_W-1:0] interval_o,
  output logic             in_tol_o,
  output logic             overdue_o,
  output logic             timeout_o
);

  localparam logic [CNT_W:0] TOL_X     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0] LATE_X    = (CNT_W+1)'(TOL + 1);
  localparam logic [CNT_W:0] TIMEOUT_X = (CNT_W+1)'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_x, ref_x, dev;

  assign cnt_x = {1'b0, cnt_q};
  assign ref_x = {1'b0, ref_i};

  // Rebase keeps the count aligned to the predicted event grid after a
  // missed sync, so a late event is still measured against one period.
  always_comb begin
    cnt_d = cnt_q;
    if (ev_i) begin
      cnt_d = CNT_W'(1);
    end else if (rebase_i) begin
      cnt_d = cnt_q - ref_i;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dev        = (cnt_x >= ref_x) ? (cnt_x - ref_x) : (ref_x - cnt_x);
  assign in_tol_o   = (dev <= TOL_X);
  assign overdue_o  = (cnt_x == ref_x + LATE_X);
  assign timeout_o  = (cnt_x >= TIMEOUT_X);
  assign interval_o = cnt_q;

endmodule

// File: rtl/sync_lock_sequencer.sv
// Qualifies left/right sync falls, tracks the sync interval and runs the
// IDLE/ACQUIRE/LOCKED/HOLDOVER lock machine that gates capture pulses.
module sync_lock_sequencer
  import sync_lock_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned TOL        = 64,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sync_lock_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  side_e            last_side_q, last_side_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       miss_q, miss_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic             first_q, first_d;
  logic             capture_en_q, capture_en_d;
  logic             sync_err_q, sync_err_d;
  logic             side_err_q, side_err_d;
  logic             lock_lost_q, lock_lost_d;

  logic             ev, both, same_side, side_bad, good;
  logic             is_locked, timeout, overdue;
  side_e            ev_side;
  logic [4:0]       good_inc, miss_inc;
  logic [CNT_W-1:0] interval;
  logic             in_tol, overdue_hit, timeout_hit;

  assign ev        = bus.lsync_fall | bus.rsync_fall;
  assign both      = bus.lsync_fall & bus.rsync_fall;
  assign ev_side   = bus.rsync_fall ? SIDE_R : SIDE_L;
  assign is_locked = (state_q == ST_LOCKED) || (state_q == ST_HOLDOVER);
  assign same_side = ev && !both && (state_q != ST_IDLE) && (ev_side == last_side_q);
  assign side_bad  = both | same_side;
  assign good      = in_tol & ~side_bad;
  assign good_inc  = {1'b0, good_q} + 5'd1;
  assign miss_inc  = {1'b0, miss_q} + 5'd1;
  assign timeout   = (state_q != ST_IDLE) && !ev && timeout_hit;
  assign overdue   = is_locked && !ev && !timeout && overdue_hit;

  sync_lock_sequencer_interval_meter #(
    .CNT_W   (CNT_W),
    .TOL     (TOL),
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .clk        (clk),
    .reset_n    (reset_n),
    .ev_i       (ev),
    .rebase_i   (overdue),
    .ref_i      (ref_q),
    .interval_o (interval),
    .in_tol_o   (in_tol),
    .overdue_o  (overdue_hit),
    .timeout_o  (timeout_hit)
  );

  always_comb begin
    state_d      = state_q;
    last_side_d  = last_side_q;
    good_d       = good_q;
    miss_d       = miss_q;
    ref_d        = ref_q;
    first_d      = first_q;
    sync_err_d   = 1'b0;
    side_err_d   = side_bad;
    lock_lost_d  = 1'b0;
    capture_en_d = bus.sync_start_stable & is_locked;

    if (ev && !both) begin
      last_side_d = ev_side;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ev) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
          first_d = 1'b1;
        end
      end

      ST_ACQUIRE: begin
        if (timeout) begin
          state_d = ST_IDLE;
          miss_d  = '0;
        end else if (ev) begin
          if (first_q) begin
            ref_d   = interval;
            good_d  = '0;
            first_d = 1'b0;
          end else if (good) begin
            good_d = good_inc[3:0];
            if (good_inc >= 5'(LOCK_COUNT)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            ref_d      = interval;
            good_d     = '0;
            sync_err_d = 1'b1;
          end
        end
      end

      ST_LOCKED: begin
        if (timeout) begin
          state_d = ST_IDLE;
          miss_d  = '0;
        end else if ((ev && !good) || overdue) begin
          sync_err_d = ev;
          miss_d     = 4'd1;
          state_d    = ST_HOLDOVER;
        end
      end

      ST_HOLDOVER: begin
        if (timeout) begin
          state_d = ST_IDLE;
          miss_d  = '0;
        end else if (ev && good) begin
          state_d = ST_LOCKED;
          miss_d  = '0;
        end else if (ev || overdue) begin
          sync_err_d = ev;
          miss_d     = miss_inc[3:0];
          if (miss_inc >= 5'(MISS_LIMIT)) begin
            state_d     = ST_ACQUIRE;
            lock_lost_d = 1'b1;
            good_d      = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_side_q  <= SIDE_L;
      good_q       <= '0;
      miss_q       <= '0;
      ref_q        <= '0;
      first_q      <= 1'b0;
      capture_en_q <= 1'b0;
      sync_err_q   <= 1'b0;
      side_err_q   <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_side_q  <= last_side_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      ref_q        <= ref_d;
      first_q      <= first_d;
      capture_en_q <= capture_en_d;
      sync_err_q   <= sync_err_d;
      side_err_q   <= side_err_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign bus.capture_en   = capture_en_q;
  assign bus.locked       = (state_q == ST_LOCKED) || (state_q == ST_HOLDOVER);
  assign bus.state        = state_q;
  assign bus.ref_interval = ref_q;
  assign bus.miss_cnt     = miss_q;
  assign bus.sync_err     = sync_err_q;
  assign bus.side_err     = side_err_q;
  assign bus.lock_lost    = lock_lost_q;

endmodule

// File: tb/tb_sync_lock_sequencer.sv
// Directed bench for sync_lock_sequencer: an event table with hand-computed
// expectations plus sequences for overdue/holdover, timeout and reset.
module tb_sync_lock_sequencer;

  logic clk;
  logic reset_n;

  sync_lock_sequencer_if #(.CNT_W(32)) bus ();

  sync_lock_sequencer #(
    .CNT_W      (32),
    .LOCK_COUNT (4),
    .MISS_LIMIT (3),
    .TOL        (64),
    .TIMEOUT    (12000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        l;
    logic        r;
    int unsigned gap;
    logic [1:0]  st;
    logic [31:0] rf;
    logic [3:0]  miss;
    logic        serr;
    logic        sderr;
  } vec_t;

  vec_t tv [24];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(input logic l, input logic r, input int unsigned gap,
                              input logic [1:0] st, input logic [31:0] rf,
                              input logic [3:0] miss, input logic serr, input logic sderr);
    vec_t v;
    v.l = l; v.r = r; v.gap = gap; v.st = st; v.rf = rf;
    v.miss = miss; v.serr = serr; v.sderr = sderr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs are set just after a falling edge, sampled on the next rising
  // edge, and outputs are read at the following falling edge.
  task automatic step(input logic l, input logic r, input logic s);
    bus.lsync_fall        = l;
    bus.rsync_fall        = r;
    bus.sync_start_stable = s;
    @(negedge clk);
    bus.lsync_fall        = 1'b0;
    bus.rsync_fall        = 1'b0;
    bus.sync_start_stable = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      idle(tv[i].gap - 1);
      step(tv[i].l, tv[i].r, 1'b0);
      check($sformatf("v%0d state", i),     32'(bus.state),        32'(tv[i].st));
      check($sformatf("v%0d locked", i),    32'(bus.locked),       32'(tv[i].st[1]));
      check($sformatf("v%0d ref", i),       bus.ref_interval,      tv[i].rf);
      check($sformatf("v%0d miss", i),      32'(bus.miss_cnt),     32'(tv[i].miss));
      check($sformatf("v%0d sync_err", i),  32'(bus.sync_err),     32'(tv[i].serr));
      check($sformatf("v%0d side_err", i),  32'(bus.side_err),     32'(tv[i].sderr));
      check($sformatf("v%0d lock_lost", i), 32'(bus.lock_lost),    32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"},     32'(bus.state),      32'd0);
    check({tag, " locked"},    32'(bus.locked),     32'd0);
    check({tag, " capture"},   32'(bus.capture_en), 32'd0);
    check({tag, " ref"},       bus.ref_interval,    32'd0);
    check({tag, " miss"},      32'(bus.miss_cnt),   32'd0);
    check({tag, " sync_err"},  32'(bus.sync_err),   32'd0);
    check({tag, " side_err"},  32'(bus.side_err),   32'd0);
    check({tag, " lock_lost"}, 32'(bus.lock_lost),  32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Lock at 2000 (silent load + 4 good), then in-lock error cases.
    tv[0]  = mk(1'b1, 1'b0, 32'd5,    2'd1, 32'd0,    4'd0, 1'b0, 1'b0);
    tv[1]  = mk(1'b0, 1'b1, 32'd2000, 2'd1, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[2]  = mk(1'b1, 1'b0, 32'd2000, 2'd1, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[3]  = mk(1'b0, 1'b1, 32'd2000, 2'd1, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[4]  = mk(1'b1, 1'b0, 32'd2000, 2'd1, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[5]  = mk(1'b0, 1'b1, 32'd2000, 2'd2, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[6]  = mk(1'b1, 1'b0, 32'd1900, 2'd3, 32'd2000, 4'd1, 1'b1, 1'b0);
    tv[7]  = mk(1'b0, 1'b1, 32'd2000, 2'd2, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[8]  = mk(1'b1, 1'b0, 32'd2064, 2'd2, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[9]  = mk(1'b0, 1'b1, 32'd1936, 2'd2, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[10] = mk(1'b1, 1'b0, 32'd1935, 2'd3, 32'd2000, 4'd1, 1'b1, 1'b0);
    tv[11] = mk(1'b0, 1'b1, 32'd2000, 2'd2, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[12] = mk(1'b1, 1'b1, 32'd2000, 2'd3, 32'd2000, 4'd1, 1'b1, 1'b1);
    tv[13] = mk(1'b1, 1'b0, 32'd2000, 2'd2, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[14] = mk(1'b1, 1'b0, 32'd2000, 2'd3, 32'd2000, 4'd1, 1'b1, 1'b1);
    tv[15] = mk(1'b0, 1'b1, 32'd2000, 2'd2, 32'd2000, 4'd0, 1'b0, 1'b0);
    // From IDLE: same side twice in ACQUIRE reloads ref and restarts count.
    tv[16] = mk(1'b1, 1'b0, 32'd5,    2'd1, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[17] = mk(1'b0, 1'b1, 32'd2000, 2'd1, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[18] = mk(1'b1, 1'b0, 32'd2000, 2'd1, 32'd2000, 4'd0, 1'b0, 1'b0);
    tv[19] = mk(1'b1, 1'b0, 32'd1500, 2'd1, 32'd1500, 4'd0, 1'b1, 1'b1);
    tv[20] = mk(1'b0, 1'b1, 32'd1500, 2'd1, 32'd1500, 4'd0, 1'b0, 1'b0);
    tv[21] = mk(1'b1, 1'b0, 32'd1500, 2'd1, 32'd1500, 4'd0, 1'b0, 1'b0);
    tv[22] = mk(1'b0, 1'b1, 32'd1500, 2'd1, 32'd1500, 4'd0, 1'b0, 1'b0);
    tv[23] = mk(1'b1, 1'b0, 32'd1500, 2'd2, 32'd1500, 4'd0, 1'b0, 1'b0);

    reset_n               = 1'b0;
    bus.lsync_fall        = 1'b0;
    bus.rsync_fall        = 1'b0;
    bus.sync_start_stable = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    run_range(0, 15);

    // Capture gating while LOCKED: one-cycle-late copy of the strobe.
    step(1'b0, 1'b0, 1'b1);
    check("cap locked hi", 32'(bus.capture_en), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("cap locked lo", 32'(bus.capture_en), 32'd0);

    // Sync stops: overdue at interval count 2065, then every 2001 cycles.
    idle(2062);
    check("pre-overdue state", 32'(bus.state), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    check("overdue1 state", 32'(bus.state), 32'd3);
    check("overdue1 miss", 32'(bus.miss_cnt), 32'd1);
    check("overdue1 sync_err", 32'(bus.sync_err), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("cap holdover", 32'(bus.capture_en), 32'd1);
    idle(1999);
    check("pre-overdue2 miss", 32'(bus.miss_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("overdue2 miss", 32'(bus.miss_cnt), 32'd2);
    check("overdue2 state", 32'(bus.state), 32'd3);
    idle(2000);
    check("pre-overdue3 state", 32'(bus.state), 32'd3);
    step(1'b0, 1'b0, 1'b0);
    check("lost state", 32'(bus.state), 32'd1);
    check("lost pulse", 32'(bus.lock_lost), 32'd1);
    check("lost miss", 32'(bus.miss_cnt), 32'd3);
    check("lost locked", 32'(bus.locked), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("lost pulse end", 32'(bus.lock_lost), 32'd0);
    check("cap acquire", 32'(bus.capture_en), 32'd0);

    // No events in ACQUIRE: timeout back to IDLE at count 12000.
    idle(11934);
    check("pre-timeout state", 32'(bus.state), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("timeout state", 32'(bus.state), 32'd0);
    check("timeout miss", 32'(bus.miss_cnt), 32'd0);
    check("timeout ref", bus.ref_interval, 32'd2000);

    run_range(16, 23);

    // Asynchronous reset while LOCKED, then relock from scratch.
    step(1'b0, 1'b0, 1'b1);
    check("cap pre-reset", 32'(bus.capture_en), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    check_all_zero("after reset");
    run_range(0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
